// File: rtl/cpu_pkg.sv
// Shared opcode, funct and ALU-code constants for the MIPS-style core.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU with zero flag; unknown operation codes produce zero.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0]  alu_ctr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_out,
    output logic        zf
);

    always_comb begin
        alu_out = 32'h0;
        case (alu_ctr)
            ALU_AND: alu_out = a & b;
            ALU_OR:  alu_out = a | b;
            ALU_ADD: alu_out = a + b;
            ALU_SUB: alu_out = a - b;
            ALU_SLT: alu_out = {31'h0, ($signed(a) < $signed(b))};
            ALU_NOR: alu_out = ~(a | b);
            default: alu_out = 32'h0;
        endcase
    end

    assign zf = (alu_out == 32'h0);

endmodule

// File: rtl/cpu_ifetch_decode_exec.sv
// Fetch from a loadable instruction memory, decode the registered instruction,
// and execute it on operands supplied by the external register file.
module cpu_ifetch_decode_exec
    import cpu_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        pc,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    input  logic [31:0]        src_data,
    input  logic [31:0]        rt_data,
    output logic [31:0]        inst,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [31:0]        imm_ext,
    output logic [25:0]        imm26,
    output logic [3:0]         alu_ctr,
    output logic               reg_dst,
    output logic               reg_wrt,
    output logic               mem_read,
    output logic               mem_wrt,
    output logic               mem_reg,
    output logic               alu_src,
    output logic               branch,
    output logic               jump,
    output logic               illegal,
    output logic [31:0]        alu_out,
    output logic               zf
);

    localparam int DEPTH = 2 ** IMEM_AW;

    logic [31:0]        imem [0:DEPTH-1];
    logic [IMEM_AW-1:0] fetch_addr;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic [31:0]        alu_b;
    logic               unused_pc_bits;

    assign fetch_addr     = pc[IMEM_AW+1:2];
    assign unused_pc_bits = ^{pc[31:IMEM_AW+2], pc[1:0]};

    // Memory has no reset so a program can be loaded while the core is held in reset.
    always_ff @(posedge clk) begin
        if (imem_we)
            imem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inst <= 32'h0;
        else
            inst <= imem[fetch_addr];
    end

    assign op    = inst[31:26];
    assign funct = inst[5:0];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign imm26 = inst[25:0];

    assign imm_ext = (op == OP_ORI) ? {16'h0, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};

    always_comb begin
        alu_ctr  = ALU_ADD;
        reg_dst  = 1'b0;
        reg_wrt  = 1'b0;
        mem_read = 1'b0;
        mem_wrt  = 1'b0;
        mem_reg  = 1'b0;
        alu_src  = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_RTYPE: begin
                reg_dst = 1'b1;
                reg_wrt = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctr = ALU_ADD;
                    FN_SUB:  alu_ctr = ALU_SUB;
                    FN_AND:  alu_ctr = ALU_AND;
                    FN_OR:   alu_ctr = ALU_OR;
                    FN_NOR:  alu_ctr = ALU_NOR;
                    FN_SLT:  alu_ctr = ALU_SLT;
                    default: begin
                        // Unknown funct drops every control so nothing gets written.
                        reg_dst = 1'b0;
                        reg_wrt = 1'b0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                alu_src  = 1'b1;
                mem_read = 1'b1;
                mem_reg  = 1'b1;
                reg_wrt  = 1'b1;
            end
            OP_SW: begin
                alu_src = 1'b1;
                mem_wrt = 1'b1;
            end
            OP_BEQ: begin
                alu_ctr = ALU_SUB;
                branch  = 1'b1;
            end
            OP_J: begin
                alu_ctr = ALU_AND;
                jump    = 1'b1;
            end
            OP_ADDI: begin
                alu_src = 1'b1;
                reg_wrt = 1'b1;
            end
            OP_ORI: begin
                alu_ctr = ALU_OR;
                alu_src = 1'b1;
                reg_wrt = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_b = alu_src ? imm_ext : rt_data;

    cpu_alu u_alu (
        .alu_ctr (alu_ctr),
        .a       (src_data),
        .b       (alu_b),
        .alu_out (alu_out),
        .zf      (zf)
    );

endmodule

// File: tb/tb_cpu_ifetch_decode_exec.sv
// Directed, table-driven bench for fetch, decode and ALU of cpu_ifetch_decode_exec.
module tb_cpu_ifetch_decode_exec;

    localparam int IMEM_AW = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [31:0]        pc;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;
    logic [31:0]        src_data;
    logic [31:0]        rt_data;
    logic [31:0]        inst;
    logic [4:0]         rs, rt, rd;
    logic [31:0]        imm_ext;
    logic [25:0]        imm26;
    logic [3:0]         alu_ctr;
    logic reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump, illegal;
    logic [31:0]        alu_out;
    logic               zf;

    int num_checks = 0;
    int num_fails  = 0;

    cpu_ifetch_decode_exec #(.IMEM_AW(IMEM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .src_data(src_data), .rt_data(rt_data),
        .inst(inst), .rs(rs), .rt(rt), .rd(rd), .imm_ext(imm_ext), .imm26(imm26),
        .alu_ctr(alu_ctr), .reg_dst(reg_dst), .reg_wrt(reg_wrt), .mem_read(mem_read),
        .mem_wrt(mem_wrt), .mem_reg(mem_reg), .alu_src(alu_src), .branch(branch),
        .jump(jump), .illegal(illegal), .alu_out(alu_out), .zf(zf)
    );

    always #5 clk = ~clk;

    // {reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump}
    typedef struct {
        logic [31:0] instr;
        logic [31:0] src;
        logic [31:0] rtd;
        logic [3:0]  ctr;
        logic [7:0]  ctrl;
        logic        ill;
        logic [31:0] imm;
        logic [31:0] out;
        logic        z;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic logic [7:0] ctrl_bus();
        return {reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadWord(input int addr, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_waddr = IMEM_AW'(addr);
        imem_wdata = data;
        tick();
        imem_we    = 1'b0;
    endtask

    task automatic applyStimulus(input int idx);
        loadWord(idx + 16, vecs[idx].instr);
        pc       = 32'((idx + 16) * 4);
        src_data = vecs[idx].src;
        rt_data  = vecs[idx].rtd;
        tick();
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h012A4020, 32'h5,        32'h7,        4'b0010, 8'b1100_0000, 1'b0, 32'h00004020, 32'hC,        1'b0};
        vecs[1]  = '{32'h1109FFFF, 32'h1234,     32'h1234,     4'b0110, 8'b0000_0010, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[2]  = '{32'h8D28FFFC, 32'h100,      32'h0,        4'b0010, 8'b0110_1100, 1'b0, 32'hFFFFFFFC, 32'hFC,       1'b0};
        vecs[3]  = '{32'h3528FFFF, 32'h0,        32'h0,        4'b0001, 8'b0100_0100, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 1'b0};
        vecs[4]  = '{32'h012A402A, 32'hFFFFFFFF, 32'h1,        4'b0111, 8'b1100_0000, 1'b0, 32'h0000402A, 32'h1,        1'b0};
        vecs[5]  = '{32'h012A402A, 32'h1,        32'hFFFFFFFF, 4'b0111, 8'b1100_0000, 1'b0, 32'h0000402A, 32'h0,        1'b1};
        vecs[6]  = '{32'h012A4027, 32'h0,        32'h0,        4'b1100, 8'b1100_0000, 1'b0, 32'h00004027, 32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{32'h08000010, 32'hF0,       32'h3C,       4'b0000, 8'b0000_0001, 1'b0, 32'h00000010, 32'h30,       1'b0};
        vecs[8]  = '{32'hFC000000, 32'h3,        32'h4,        4'b0010, 8'b0000_0000, 1'b1, 32'h00000000, 32'h7,        1'b0};
        vecs[9]  = '{32'h012A4022, 32'h3,        32'h5,        4'b0110, 8'b1100_0000, 1'b0, 32'h00004022, 32'hFFFFFFFE, 1'b0};
        vecs[10] = '{32'h012A4024, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 8'b1100_0000, 1'b0, 32'h00004024, 32'h0F000F00, 1'b0};
        vecs[11] = '{32'h012A4025, 32'hFF00FF00, 32'h0FF00FF0, 4'b0001, 8'b1100_0000, 1'b0, 32'h00004025, 32'hFFF0FFF0, 1'b0};
        vecs[12] = '{32'h2128FFFF, 32'h1,        32'h55,       4'b0010, 8'b0100_0100, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[13] = '{32'hAD280004, 32'h100,      32'h77,       4'b0010, 8'b0001_0100, 1'b0, 32'h00000004, 32'h104,      1'b0};
        vecs[14] = '{32'h012A4000, 32'h2,        32'h3,        4'b0010, 8'b0000_0000, 1'b1, 32'h00004000, 32'h5,        1'b0};
        vecs[15] = '{32'h012A4020, 32'hFFFFFFFF, 32'h1,        4'b0010, 8'b1100_0000, 1'b0, 32'h00004020, 32'h0,        1'b1};

        rst_n = 1'b0; pc = 32'h0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        src_data = '0; rt_data = '0;

        // Reset: load while held in reset, inst must stay zero and decode as illegal
        #2;
        loadWord(1, 32'h012A4020);
        loadWord(2, 32'h11111111);
        checkOutput("reset_inst", inst, 32'h0);
        checkOutput("reset_illegal", 32'(illegal), 32'h1);
        checkOutput("reset_reg_wrt", 32'(reg_wrt), 32'h0);

        rst_n = 1'b1;
        pc = 32'h4; src_data = 32'd5; rt_data = 32'd7;
        tick();
        checkOutput("fetch_inst", inst, 32'h012A4020);
        checkOutput("fetch_rs", 32'(rs), 32'd9);
        checkOutput("fetch_rt", 32'(rt), 32'd10);
        checkOutput("fetch_rd", 32'(rd), 32'd8);
        checkOutput("fetch_ctrl", 32'(ctrl_bus()), 32'hC0);
        checkOutput("fetch_alu_ctr", 32'(alu_ctr), 32'h2);
        checkOutput("fetch_alu_out", alu_out, 32'd12);
        checkOutput("fetch_zf", 32'(zf), 32'h0);

        // Table-driven decode and execute
        for (int i = 0; i < NV; i++) begin
            applyStimulus(i);
            checkOutput($sformatf("v%0d_inst", i), inst, vecs[i].instr);
            checkOutput($sformatf("v%0d_alu_ctr", i), 32'(alu_ctr), 32'(vecs[i].ctr));
            checkOutput($sformatf("v%0d_ctrl", i), 32'(ctrl_bus()), 32'(vecs[i].ctrl));
            checkOutput($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
            checkOutput($sformatf("v%0d_imm_ext", i), imm_ext, vecs[i].imm);
            checkOutput($sformatf("v%0d_alu_out", i), alu_out, vecs[i].out);
            checkOutput($sformatf("v%0d_zf", i), 32'(zf), 32'(vecs[i].z));
            if (i == 7)
                checkOutput("jump_imm26", 32'(imm26), 32'h0000010);
        end

        // Address wrap and ignored byte offset
        pc = 32'(4 * (2 ** IMEM_AW) + 4);
        tick();
        checkOutput("wrap_inst", inst, 32'h012A4020);
        pc = 32'h8;
        tick();
        checkOutput("word2_inst", inst, 32'h11111111);
        pc = 32'h6;
        tick();
        checkOutput("byte_offset_inst", inst, 32'h012A4020);

        // Same-cycle write and fetch of word 2: old data first, new data next cycle
        pc = 32'h8;
        loadWord(2, 32'h22222222);
        checkOutput("collide_old", inst, 32'h11111111);
        tick();
        checkOutput("collide_new", inst, 32'h22222222);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_inst", inst, 32'h0);
        checkOutput("async_reset_illegal", 32'(illegal), 32'h1);
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_inst", inst, 32'h22222222);

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
        $finish;
    end

endmodule
